dc_hazard_unit: RTL and testbench
=================================

Name: dc_hazard_unit

Overview:
- Parametrised decode/control stage for the 8-bit MIPS pipeline, sitting between fetch and execute.
- Decodes each instruction into opcode, immediate and memory-control strobes.
- Tracks in-flight destination registers over a configurable forwarding depth and generates forwarding mux selects.
- Adds a valid/ready handshake, load-use interlock with bubble insertion, branch flush and register-0 suppression.

Parameters:
- RA_W, 5: register address width.
- IMM_W, 8: immediate width; immediate field is ins[IMM_W:1].
- FWD_DEPTH, 3: number of downstream stages tracked for forwarding (1..7).
- INS_W, 24: instruction width; must be >= 5+3*RA_W+1.
- SEL_W: derived, clog2(FWD_DEPTH+1); width of the mux selects.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- ins  in  INS_W  instruction. Fields: opcode = ins[INS_W-1 -: 5], rd next RA_W bits, ra next RA_W, rb next RA_W.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decode accepts this cycle.
- flush  in  1  branch resolved taken; kill the decode-stage contents.
- out_valid  out  1  decoded instruction valid toward execute.
- op_dec  out  5  registered opcode; 0 (NOP) on a bubble.
- imm  out  IMM_W  registered immediate.
- imm_sel  out  1  immediate-class instruction (opcode 01xxx).
- mux_sel_a  out  SEL_W  forwarding select for operand A.
- mux_sel_b  out  SEL_W  forwarding select for operand B.
- mem_en_ex  out  1  memory access enable, execute+1 stage.
- mem_rw_ex  out  1  1 = store, 0 = load; meaningful only when mem_en_ex = 1.
- mem_mux_sel_dm  out  1  writeback takes memory data (load), one cycle after mem_en_ex.
- rw_dm  out  RA_W  destination register of the oldest tracked stage.
- rw_en_dm  out  1  the oldest tracked stage writes rw_dm.

Behaviour:
- Opcode classes:
  - JMP = 11000.
  - CJMP = 111xx.
  - LD = 10100.
  - ST = 10101.
  - IMM = 01xxx.
  - Everything else is ALU.
  - JMP, CJMP and ST do not write rd; their ra/rb/rd are forced to 0 before comparison.
- Accept: an instruction is accepted when in_valid && in_ready. It appears on the outputs the next cycle (1-cycle latency) with out_valid = 1.
- Tracking pipe: FWD_DEPTH entries {valid, wr, rd}.
  - Entry 1 = instruction currently on the outputs.
  - The pipe shifts every cycle. A bubble enters as valid = 0.
- Forwarding: mux_sel_a is the smallest k in 1..FWD_DEPTH where entry k is valid, wr = 1, rd == ra and ra != 0; 0 if there is no match. mux_sel_b is computed the same way using rb. Both selects are registered with the instruction.
- Load-use interlock:
  - If the accepted-candidate ra or rb (nonzero) equals entry-1 rd and entry 1 is an LD, in_ready = 0 for one cycle.
  - A bubble is issued: out_valid = 0, op_dec = 0, all strobes 0.
  - The instruction is accepted the following cycle, with select = 2 for the matching operand.
- in_ready is otherwise 1. Decode has no downstream backpressure.
- flush:
  - The next-cycle outputs become a bubble regardless of in_valid.
  - in_ready is 1 during flush, but the beat presented is discarded.
  - Tracking entries already downstream are unaffected.
  - flush takes priority over the interlock.
- Memory strobes:
  - mem_en_ex = 1 one cycle after out_valid for LD/ST.
  - mem_rw_ex = 1 for ST.
  - mem_mux_sel_dm = 1 one cycle after mem_en_ex for LD only.
- rw_dm and rw_en_dm mirror entry FWD_DEPTH (rd and valid && wr).
- Reset:
  - All outputs and all tracking entries are 0.
  - in_ready = 0 during the reset cycle and 1 on the first cycle after reset deasserts.
  - Reset mid-stall cancels the stall and drops the held instruction.
- Simultaneous multiple matches: the youngest stage (smallest k) wins.

Optional Feature:
- Macro DC_HAZARD_STALL_CNT_EN.
- When defined:
  - Adds port stall_count  out  16, a saturating count of interlock bubbles (flush bubbles not counted).
  - Cleared by reset; holds at 16'hFFFF.
- When undefined: the port and counter logic are absent; no other behaviour changes.

Test Plan:
- Reset then idle (in_valid = 0, 5 cycles) -> out_valid = 0, op_dec = 0, all selects = 0, rw_en_dm = 0.
- ALU r3 <- r1,r2 then ALU r4 <- r3,r3 back-to-back -> second instruction has mux_sel_a = 1 and mux_sel_b = 1; no stall.
- LD r5 then ALU r6 <- r5,r2 -> in_ready = 0 for exactly one cycle, one bubble issued, then mux_sel_a = 2 and mux_sel_b = 0. mem_en_ex = 1 and mem_rw_ex = 0 one cycle after the LD's out_valid, and mem_mux_sel_dm = 1 on the next cycle.
- Writes to r0 followed by a read of r0 -> mux_sel_a = 0; rw_dm = 0 with rw_en_dm = 1 after FWD_DEPTH cycles.
- ST r7 then JMP, with flush asserted in the JMP-decode cycle -> ST gives mem_rw_ex = 1 and rw_en_dm = 0; the instruction following the JMP is dropped and the output is a bubble.
- FWD_DEPTH = 5, same rd written 2 and 4 stages ahead -> mux_sel_a = 2 (youngest wins). With DC_HAZARD_STALL_CNT_EN defined and 3 load-use pairs -> stall_count = 3.

Source files
------------

// File: rtl/dc_hazard_unit.sv
// ---------------------------------------------------------------------------
// dc_hazard_unit -- decode/control stage of the 8-bit MIPS pipeline.
//
// Decodes one instruction per cycle into opcode, immediate and memory strobes.
// It tracks the destination registers of the last FWD_DEPTH issued slots and
// produces operand forwarding selects. It also inserts a one-cycle bubble on a
// load-use hazard and turns the next issue slot into a bubble on a taken-branch
// flush.
//
// Optional build macro: DC_HAZARD_STALL_CNT_EN adds the stall_count output,
// a saturating count of load-use bubbles.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   ins               instruction {opcode[5], rd, ra, rb, ...}; imm = ins[IMM_W:1]
//   in_valid/in_ready fetch handshake; accept = in_valid && in_ready
//   flush             branch taken: the beat presented this cycle is discarded
//   out_valid         decoded instruction valid toward execute
//   op_dec, imm       registered opcode (0 on a bubble) and immediate
//   imm_sel           immediate-class instruction (opcode 01xxx)
//   mux_sel_a/b       forwarding selects: k = producer k slots ahead, 0 = regfile
//   mem_en_ex         LD/ST memory enable, one cycle after out_valid
//   mem_rw_ex         1 = store, 0 = load (qualifies mem_en_ex)
//   mem_mux_sel_dm    writeback takes memory data, one cycle after a load's mem_en_ex
//   rw_dm, rw_en_dm   destination and write enable of the oldest tracked slot
//   stall_count       (DC_HAZARD_STALL_CNT_EN only) load-use bubble count
// ---------------------------------------------------------------------------
module dc_hazard_unit #(
    parameter int RA_W      = 5,
    parameter int IMM_W     = 8,
    parameter int FWD_DEPTH = 3,
    parameter int INS_W     = 24,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INS_W-1:0] ins,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [4:0]       op_dec,
    output logic [IMM_W-1:0] imm,
    output logic             imm_sel,
    output logic [SEL_W-1:0] mux_sel_a,
    output logic [SEL_W-1:0] mux_sel_b,
    output logic             mem_en_ex,
    output logic             mem_rw_ex,
    output logic             mem_mux_sel_dm,
    output logic [RA_W-1:0]  rw_dm,
    output logic             rw_en_dm
`ifdef DC_HAZARD_STALL_CNT_EN
    ,
    output logic [15:0]      stall_count
`endif
);

    localparam logic [4:0] OP_JMP = 5'b11000;
    localparam logic [4:0] OP_LD  = 5'b10100;
    localparam logic [4:0] OP_ST  = 5'b10101;

    typedef struct packed {
        logic            vld;
        logic            wr;
        logic [RA_W-1:0] rd;
    } trk_t;

    // ---------------- field extraction ----------------
    logic [4:0]      op_c;
    logic [RA_W-1:0] rd_raw, ra_raw, rb_raw;
    logic [RA_W-1:0] rd_c, ra_c, rb_c;
    logic            no_wr_c;

    assign op_c   = ins[INS_W-1 -: 5];
    assign rd_raw = ins[INS_W-6 -: RA_W];
    assign ra_raw = ins[INS_W-6-RA_W -: RA_W];
    assign rb_raw = ins[INS_W-6-2*RA_W -: RA_W];

    // Jumps and stores never write rd. Their register fields are zeroed, so they
    // neither become forwarding producers nor take part in any comparison.
    assign no_wr_c = (op_c == OP_JMP) || (op_c[4:2] == 3'b111) || (op_c == OP_ST);
    assign rd_c    = no_wr_c ? '0 : rd_raw;
    assign ra_c    = no_wr_c ? '0 : ra_raw;
    assign rb_c    = no_wr_c ? '0 : rb_raw;

    // Not every instruction bit feeds a field for every parameter set.
    logic unused_ins;
    assign unused_ins = ^ins;

    // ---------------- state ----------------
    trk_t             pipe_q [1:FWD_DEPTH];
    trk_t             pipe_d [1:FWD_DEPTH];
    logic             out_valid_q, out_valid_d;
    logic [4:0]       op_dec_q, op_dec_d;
    logic [IMM_W-1:0] imm_q, imm_d;
    logic             imm_sel_q, imm_sel_d;
    logic [SEL_W-1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_rw_q, mem_rw_d;
    logic             mem_mux_q, mem_mux_d;

    // ---------------- hazard / handshake ----------------
    logic e1_is_ld, load_use_c, accept;
    logic [SEL_W-1:0] fwd_a_c, fwd_b_c;

    // Entry 1 is the instruction on the outputs. op_dec reads 0 on a bubble, so
    // the LD opcode test alone already implies that the entry is valid.
    assign e1_is_ld   = out_valid_q && (op_dec_q == OP_LD);
    assign load_use_c = in_valid && e1_is_ld && pipe_q[1].vld &&
                        (((ra_c != '0) && (ra_c == pipe_q[1].rd)) ||
                         ((rb_c != '0) && (rb_c == pipe_q[1].rd)));

    // Flush overrides the interlock. The beat is consumed and then discarded.
    assign in_ready = !reset && (flush || !load_use_c);
    assign accept   = in_valid && in_ready && !flush;

    // Scan from oldest to youngest so the youngest match is the one that remains.
    always_comb begin
        // NOTE: every always_comb output gets a default before any conditional
        // assignment, so that no path leaves it unassigned and infers a latch.
        fwd_a_c = '0;
        fwd_b_c = '0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (pipe_q[k].vld && pipe_q[k].wr && (ra_c != '0) && (pipe_q[k].rd == ra_c))
                fwd_a_c = SEL_W'(k);
            if (pipe_q[k].vld && pipe_q[k].wr && (rb_c != '0) && (pipe_q[k].rd == rb_c))
                fwd_b_c = SEL_W'(k);
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        out_valid_d = accept;
        op_dec_d    = accept ? op_c : '0;
        imm_d       = accept ? ins[IMM_W:1] : '0;
        imm_sel_d   = accept && (op_c[4:3] == 2'b01);
        sel_a_d     = accept ? fwd_a_c : '0;
        sel_b_d     = accept ? fwd_b_c : '0;

        // The strobes follow the instruction that is on the outputs now.
        mem_en_d  = out_valid_q && ((op_dec_q == OP_LD) || (op_dec_q == OP_ST));
        mem_rw_d  = out_valid_q && (op_dec_q == OP_ST);
        mem_mux_d = mem_en_q && !mem_rw_q;

        // A bubble enters the tracking pipe as an all-zero entry.
        pipe_d[1] = '0;
        if (accept)
            pipe_d[1] = trk_t'{vld: 1'b1, wr: !no_wr_c, rd: rd_c};
        for (int k = 2; k <= FWD_DEPTH; k++)
            pipe_d[k] = pipe_q[k-1];
    end

    // NOTE: the tracking entries are a short shift register, not a RAM, so they
    // are cleared by reset along with everything else; a mid-stall reset must not
    // leave a stale producer behind.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before the edge.
        if (reset) begin
            out_valid_q <= 1'b0;
            op_dec_q    <= '0;
            imm_q       <= '0;
            imm_sel_q   <= 1'b0;
            sel_a_q     <= '0;
            sel_b_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_mux_q   <= 1'b0;
            for (int k = 1; k <= FWD_DEPTH; k++)
                pipe_q[k] <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            op_dec_q    <= op_dec_d;
            imm_q       <= imm_d;
            imm_sel_q   <= imm_sel_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            mem_mux_q   <= mem_mux_d;
            for (int k = 1; k <= FWD_DEPTH; k++)
                pipe_q[k] <= pipe_d[k];
        end
    end

    assign out_valid      = out_valid_q;
    assign op_dec         = op_dec_q;
    assign imm            = imm_q;
    assign imm_sel        = imm_sel_q;
    assign mux_sel_a      = sel_a_q;
    assign mux_sel_b      = sel_b_q;
    assign mem_en_ex      = mem_en_q;
    assign mem_rw_ex      = mem_rw_q;
    assign mem_mux_sel_dm = mem_mux_q;
    assign rw_dm          = pipe_q[FWD_DEPTH].rd;
    assign rw_en_dm       = pipe_q[FWD_DEPTH].vld && pipe_q[FWD_DEPTH].wr;

`ifdef DC_HAZARD_STALL_CNT_EN
    // Counts interlock bubbles only. A flush bubble is never counted, because
    // flush overrides the interlock.
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= '0;
        else if (load_use_c && !flush && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dc_hazard_unit.sv
// Self-checking bench for dc_hazard_unit: a table of per-cycle vectors on the
// default configuration, plus hand-written sequences for depth-5 priority and
// the load-use stall counter.
module tb_dc_hazard_unit;

    localparam logic [4:0] OP_ALU = 5'h01;
    localparam logic [4:0] OP_IMM = 5'h0B;
    localparam logic [4:0] OP_LD  = 5'h14;
    localparam logic [4:0] OP_ST  = 5'h15;
    localparam logic [4:0] OP_JMP = 5'h18;
    localparam logic [23:0] IDLE  = 24'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [23:0] ins = '0;

    // default instance (FWD_DEPTH = 3)
    logic       in_ready, out_valid, imm_sel, mem_en_ex, mem_rw_ex, mem_mux_sel_dm, rw_en_dm;
    logic [4:0] op_dec, rw_dm;
    logic [7:0] imm;
    logic [1:0] mux_sel_a, mux_sel_b;
    // depth-5 instance
    logic       in_ready5, out_valid5, imm_sel5, mem_en_ex5, mem_rw_ex5, mem_mux_sel_dm5, rw_en_dm5;
    logic [4:0] op_dec5, rw_dm5;
    logic [7:0] imm5;
    logic [2:0] mux_sel_a5, mux_sel_b5;
`ifdef DC_HAZARD_STALL_CNT_EN
    logic [15:0] stall_count, stall_count5;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "timeout");
    end

    dc_hazard_unit u_dut (
        .clk(clk), .reset(reset), .ins(ins), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .op_dec(op_dec), .imm(imm), .imm_sel(imm_sel),
        .mux_sel_a(mux_sel_a), .mux_sel_b(mux_sel_b), .mem_en_ex(mem_en_ex),
        .mem_rw_ex(mem_rw_ex), .mem_mux_sel_dm(mem_mux_sel_dm), .rw_dm(rw_dm),
        .rw_en_dm(rw_en_dm)
`ifdef DC_HAZARD_STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );

    dc_hazard_unit #(.FWD_DEPTH(5)) u_dut5 (
        .clk(clk), .reset(reset), .ins(ins), .in_valid(in_valid), .in_ready(in_ready5),
        .flush(flush), .out_valid(out_valid5), .op_dec(op_dec5), .imm(imm5), .imm_sel(imm_sel5),
        .mux_sel_a(mux_sel_a5), .mux_sel_b(mux_sel_b5), .mem_en_ex(mem_en_ex5),
        .mem_rw_ex(mem_rw_ex5), .mem_mux_sel_dm(mem_mux_sel_dm5), .rw_dm(rw_dm5),
        .rw_en_dm(rw_en_dm5)
`ifdef DC_HAZARD_STALL_CNT_EN
        , .stall_count(stall_count5)
`endif
    );

    typedef struct {
        logic        rst, vld, fl;
        logic [23:0] ins;
        logic        rdy;
        logic        ov;
        logic [4:0]  op;
        logic [7:0]  imm;
        logic        isel;
        logic [1:0]  sa, sb;
        logic        men, mrw, mmx;
        logic [4:0]  rwd;
        logic        rwen;
    } vec_t;

    vec_t tbl[$];

    logic [27:0] dut_outs;
    assign dut_outs = {out_valid, op_dec, imm, imm_sel, mux_sel_a, mux_sel_b,
                       mem_en_ex, mem_rw_ex, mem_mux_sel_dm, rw_dm, rw_en_dm};

    function automatic logic [27:0] pack_exp(input vec_t e);
        return {e.ov, e.op, e.imm, e.isel, e.sa, e.sb, e.men, e.mrw, e.mmx, e.rwd, e.rwen};
    endfunction

    function automatic logic [23:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] ra, input logic [4:0] rb,
                                       input logic [3:0] lo);
        return {op, rd, ra, rb, lo};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic f, input logic [23:0] i,
                       input logic rdy, input logic ov, input logic [4:0] op,
                       input logic [7:0] im, input logic isel, input logic [1:0] sa,
                       input logic [1:0] sb, input logic men, input logic mrw,
                       input logic mmx, input logic [4:0] rwd, input logic rwen);
        vec_t e;
        e.rst = r; e.vld = v; e.fl = f; e.ins = i; e.rdy = rdy; e.ov = ov; e.op = op;
        e.imm = im; e.isel = isel; e.sa = sa; e.sb = sb; e.men = men; e.mrw = mrw;
        e.mmx = mmx; e.rwd = rwd; e.rwen = rwen;
        tbl.push_back(e);
    endtask

    task automatic drive(input logic r, input logic v, input logic f, input logic [23:0] i);
        @(negedge clk);
        reset = r; in_valid = v; flush = f; ins = i;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst vld fl ins                   | rdy ov op      imm   is sa sb men mrw mmx rwd rwen
        add(1, 0, 0, IDLE,                     0,  0, 5'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        add(1, 0, 0, IDLE,                     0,  0, 5'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, IDLE,                 1,  0, 5'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        // back-to-back ALU forwarding
        add(0, 1, 0, mk(OP_ALU, 3, 1, 2, 0),   1,  1, OP_ALU, 8'h10, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        add(0, 1, 0, mk(OP_ALU, 4, 3, 3, 0),   1,  1, OP_ALU, 8'h18, 0, 1, 1, 0, 0, 0, 5'd0, 0);
        add(0, 0, 0, IDLE,                     1,  0, 5'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5'd3, 1);
        add(0, 0, 0, IDLE,                     1,  0, 5'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5'd4, 1);
        add(0, 0, 0, IDLE,                     1,  0, 5'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        // load-use: one bubble, then select 2
        add(0, 1, 0, mk(OP_LD, 5, 1, 0, 0),    1,  1, OP_LD,  8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        add(0, 1, 0, mk(OP_ALU, 6, 5, 2, 0),   0,  0, 5'h00, 8'h00, 0, 0, 0, 1, 0, 0, 5'd0, 0);
        add(0, 1, 0, mk(OP_ALU, 6, 5, 2, 0),   1,  1, OP_ALU, 8'h10, 0, 2, 0, 0, 0, 1, 5'd5, 1);
        add(0, 0, 0, IDLE,                     1,  0, 5'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        // r0 write then r0 read
        add(0, 1, 0, mk(OP_ALU, 0, 1, 2, 0),   1,  1, OP_ALU, 8'h10, 0, 0, 0, 0, 0, 0, 5'd6, 1);
        add(0, 1, 0, mk(OP_ALU, 7, 0, 0, 0),   1,  1, OP_ALU, 8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        add(0, 0, 0, IDLE,                     1,  0, 5'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 1);
        add(0, 0, 0, IDLE,                     1,  0, 5'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5'd7, 1);
        // ST (fields zeroed: no match on r7 three ahead), JMP, flushed follower
        add(0, 1, 0, mk(OP_ST, 7, 7, 7, 0),    1,  1, OP_ST,  8'h38, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        add(0, 1, 0, mk(OP_JMP, 0, 0, 0, 0),   1,  1, OP_JMP, 8'h00, 0, 0, 0, 1, 1, 0, 5'd0, 0);
        add(0, 1, 1, mk(OP_ALU, 1, 7, 7, 0),   1,  0, 5'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        add(0, 0, 0, IDLE,                     1,  0, 5'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        // flush beats the interlock
        add(0, 1, 0, mk(OP_LD, 2, 1, 0, 0),    1,  1, OP_LD,  8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        add(0, 1, 1, mk(OP_ALU, 3, 2, 2, 0),   1,  0, 5'h00, 8'h00, 0, 0, 0, 1, 0, 0, 5'd0, 0);
        add(0, 1, 0, mk(OP_ALU, 3, 2, 2, 0),   1,  1, OP_ALU, 8'h10, 0, 2, 2, 0, 0, 1, 5'd2, 1);
        add(0, 0, 0, IDLE,                     1,  0, 5'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        // immediate class, rb-side load-use, reset mid-stall
        add(0, 1, 0, mk(OP_IMM, 4, 3, 0, 6),   1,  1, OP_IMM, 8'h03, 1, 2, 0, 0, 0, 0, 5'd3, 1);
        add(0, 1, 0, mk(OP_LD, 9, 4, 0, 0),    1,  1, OP_LD,  8'h00, 0, 1, 0, 0, 0, 0, 5'd0, 0);
        add(0, 1, 0, mk(OP_ALU, 1, 2, 9, 0),   0,  0, 5'h00, 8'h00, 0, 0, 0, 1, 0, 0, 5'd4, 1);
        add(1, 1, 0, mk(OP_ALU, 1, 2, 9, 0),   0,  0, 5'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        add(0, 1, 0, mk(OP_ALU, 1, 2, 9, 0),   1,  1, OP_ALU, 8'h48, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        add(0, 0, 0, IDLE,                     1,  0, 5'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5'd0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].fl, tbl[i].ins);
            check($sformatf("v%0d.in_ready", i), in_ready, tbl[i].rdy);
            tick();
            check($sformatf("v%0d.outs", i), dut_outs, pack_exp(tbl[i]));
        end

        // Depth 5: r8 written 4 and 2 slots ahead -> youngest (2) wins.
        // Then r10 sits 4 ahead: visible at depth 5, beyond reach at depth 3.
        drive(1, 0, 0, IDLE); tick();
        drive(0, 1, 0, mk(OP_ALU, 8, 0, 0, 0));  tick();
        drive(0, 1, 0, mk(OP_ALU, 10, 0, 0, 0)); tick();
        drive(0, 1, 0, mk(OP_ALU, 8, 0, 0, 0));  tick();
        drive(0, 1, 0, mk(OP_ALU, 11, 0, 0, 0)); tick();
        drive(0, 1, 0, mk(OP_ALU, 12, 8, 0, 0)); tick();
        check("d5.youngest_sel_a", mux_sel_a5, 3'd2);
        check("d3.youngest_sel_a", mux_sel_a, 2'd2);
        drive(0, 1, 0, mk(OP_ALU, 14, 10, 0, 0)); tick();
        check("d5.far_sel_a", mux_sel_a5, 3'd4);
        check("d3.far_sel_a", mux_sel_a, 2'd0);
        check("d5.rw_dm", {rw_en_dm5, rw_dm5}, {1'b1, 5'd10});
        check("d3.rw_dm", {rw_en_dm, rw_dm}, {1'b1, 5'd11});

        // Three load-use pairs, then a flushed one that must not count.
        drive(1, 0, 0, IDLE); tick();
        for (int p = 0; p < 3; p++) begin
            drive(0, 1, 0, mk(OP_LD, 5, 0, 0, 0)); tick();
            drive(0, 1, 0, mk(OP_ALU, 6, 5, 0, 0));
            check($sformatf("lu%0d.stall_ready", p), in_ready, 1'b0);
            tick();
            check($sformatf("lu%0d.bubble", p), out_valid, 1'b0);
            drive(0, 1, 0, mk(OP_ALU, 6, 5, 0, 0));
            check($sformatf("lu%0d.retry_ready", p), in_ready, 1'b1);
            tick();
            check($sformatf("lu%0d.sel_a", p), {out_valid, mux_sel_a}, {1'b1, 2'd2});
        end
        drive(0, 1, 0, mk(OP_LD, 5, 0, 0, 0)); tick();
        drive(0, 1, 1, mk(OP_ALU, 6, 5, 0, 0));
        check("lu_flush.ready", in_ready, 1'b1);
        tick();
        drive(0, 0, 0, IDLE); tick();
`ifdef DC_HAZARD_STALL_CNT_EN
        check("stall_count", stall_count, 16'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
